// File: rtl/lsu_mem_if.sv
// Request/response and data-RAM signal bundle for the load/store unit.
// The master drives requests and returns RAM read data; the slave is the LSU.
interface lsu_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        data_w_en;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready, data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, data_w_en, data_addr, data_in
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready, data_out,
    output req_ready, resp_valid, resp_rdata, resp_err, data_w_en, data_addr, data_in
  );
endinterface

// File: rtl/lsu_mem.sv
// Load/store unit for a word-wide data RAM with combinational read.
// Sub-word stores are done as read-modify-write through a merge cycle.
module lsu_mem #(
  parameter int unsigned ADDR_BITS = 7
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_mem_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  logic        req_ready_q, resp_valid_q, resp_err_q, data_w_en_q;
  logic [31:0] resp_rdata_q, data_in_q;
  logic        resp_err_d, data_w_en_d;
  logic [31:0] resp_rdata_d, data_in_d;
  logic        latch_c, req_err_c;
  logic [4:0]  byte_sh_c, half_sh_c;
  logic [7:0]  lane_b_c;
  logic [15:0] lane_h_c;
  logic [31:0] load_c, mask_c, ins_c, merge_c;

  // Request legality check on the live request inputs
  always_comb begin
    req_err_c = 1'b0;
    if (bus.req_size == 3'b011 || bus.req_size == 3'b110 || bus.req_size == 3'b111)
      req_err_c = 1'b1;
    if (bus.req_we && bus.req_size[2])
      req_err_c = 1'b1;
    if (bus.req_size[1:0] == 2'b01 && bus.req_addr[0])
      req_err_c = 1'b1;
    if (bus.req_size[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
      req_err_c = 1'b1;
    if ((bus.req_addr >> ADDR_BITS) != 32'd0)
      req_err_c = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    byte_sh_c = {addr_q[1:0], 3'b000};
    half_sh_c = {addr_q[1], 4'b0000};
    lane_b_c  = 8'(bus.data_out >> byte_sh_c);
    lane_h_c  = addr_q[1] ? bus.data_out[31:16] : bus.data_out[15:0];
    case (size_q)
      3'b000:  load_c = {{24{lane_b_c[7]}}, lane_b_c};
      3'b100:  load_c = {24'd0, lane_b_c};
      3'b001:  load_c = {{16{lane_h_c[15]}}, lane_h_c};
      3'b101:  load_c = {16'd0, lane_h_c};
      default: load_c = bus.data_out;
    endcase
    if (size_q[0]) begin
      mask_c = 32'h0000_FFFF << half_sh_c;
      ins_c  = 32'(wdata_q[15:0]) << half_sh_c;
    end else begin
      mask_c = 32'h0000_00FF << byte_sh_c;
      ins_c  = 32'(wdata_q[7:0]) << byte_sh_c;
    end
    merge_c = (bus.data_out & ~mask_c) | ins_c;
  end

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    latch_c      = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    data_w_en_d  = 1'b0;
    data_in_d    = 32'd0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          latch_c = 1'b1;
          if (req_err_c) begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d = ACCESS;
            // Full-word stores write during ACCESS itself
            if (bus.req_we && bus.req_size == 3'b010) begin
              data_w_en_d = 1'b1;
              data_in_d   = bus.req_wdata;
            end
          end
        end
      end
      ACCESS: begin
        resp_err_d = 1'b0;
        if (we_q) begin
          resp_rdata_d = 32'd0;
          if (size_q[1]) begin
            state_d = RESP;
          end else begin
            state_d     = MERGE_WR;
            data_w_en_d = 1'b1;
            data_in_d   = merge_c;
          end
        end else begin
          state_d      = RESP;
          resp_rdata_d = load_c;
        end
      end
      MERGE_WR: state_d = RESP;
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      data_w_en_q  <= 1'b0;
      data_in_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= (state_d == IDLE);
      resp_valid_q <= (state_d == RESP);
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      data_w_en_q  <= data_w_en_d;
      data_in_q    <= data_in_d;
    end
  end

  // Request capture at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (latch_c) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.data_w_en  = data_w_en_q;
  assign bus.data_in    = data_in_q;
  assign bus.data_addr  = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu_mem.sv
// Self-checking bench for lsu_mem: RAM model, scoreboard of expected responses,
// and per-feature scenario tasks.
module tb_lsu_mem;
  localparam int unsigned ADDR_BITS = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_if bus();
  lsu_mem #(.ADDR_BITS(ADDR_BITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          wlat;
    logic [31:0] wdin;
  } vec_t;

  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   wen_cnt = 0;
  int   wen_cyc = 0;
  int   din_leak = 0;
  logic [31:0] wen_din = 32'd0;

  // RAM model with a bench-side preload port
  logic [31:0] ram [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [31:0] pl_data = 32'd0;
  assign bus.data_out = ram[bus.data_addr[6:2]];
  always @(posedge clk) begin
    if (bus.data_w_en) ram[bus.data_addr[6:2]] <= bus.data_in;
    else if (pl_en)    ram[pl_idx] <= pl_data;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.data_w_en) begin
      wen_cnt <= wen_cnt + 1;
      wen_din <= bus.data_in;
      wen_cyc <= cyc;
    end
    if (!bus.data_w_en && bus.data_in != 32'd0) din_leak <= din_leak + 1;
  end

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 5'(idx); pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request and collect its response; latencies count from the accept edge
  task automatic run(input vec_t v, output logic [31:0] rd, output logic er, output int lat,
                     output int nw, output logic [31:0] wdin, output int wlat, output bit ok);
    int c0, w0;
    ok = 1'b0; rd = 32'd0; er = 1'b0; lat = -1; nw = 0; wdin = 32'd0; wlat = -1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_size = v.sz;
    bus.req_addr = v.a; bus.req_wdata = v.wd;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    w0 = wen_cnt;
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        rd = bus.resp_rdata; er = bus.resp_err; lat = cyc - c0 + 1; ok = 1'b1;
        break;
      end
    end
    nw = wen_cnt - w0;
    wdin = wen_din;
    wlat = (nw > 0) ? wen_cyc - c0 + 1 : 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_resp_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_resp_err: got %b want 0", bus.resp_err); end
    n_cmp++; if (bus.data_w_en !== 1'b0) begin n_bad++; $display("FAIL rst_data_w_en: got %b want 0", bus.data_w_en); end
    n_cmp++; if (bus.data_in !== 32'd0) begin n_bad++; $display("FAIL rst_data_in: got %h want 0", bus.data_in); end
    n_cmp++; if (bus.data_addr !== 32'd0) begin n_bad++; $display("FAIL rst_data_addr: got %h want 0", bus.data_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_loads;
    vec_t v[$];
    vec_t e;
    logic [31:0] rd, wdin;
    logic er;
    int lat, nw, wlat;
    bit ok;
    poke(4, 32'hDEAD_BEEF);
    sb.push_back('{1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'd0});
    run(sb[0], rd, er, lat, nw, wdin, wlat, ok);
    e = sb.pop_front();
    n_cmp++; if (!ok || rd !== e.rd) begin n_bad++; $display("FAIL lw_rdata: got %h want %h", rd, e.rd); end
    n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL lw_latency: got %0d want %0d", lat, e.lat); end
    poke(4, 32'h80FF_FFFF);
    v.push_back('{1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFF_FF80, 1'b0, 2, 0, 32'd0});
    v.push_back('{1'b0, 3'b100, 32'h13, 32'd0, 32'h0000_0080, 1'b0, 2, 0, 32'd0});
    v.push_back('{1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF_80FF, 1'b0, 2, 0, 32'd0});
    v.push_back('{1'b0, 3'b101, 32'h10, 32'd0, 32'h0000_FFFF, 1'b0, 2, 0, 32'd0});
    v.push_back('{1'b0, 3'b000, 32'h10, 32'd0, 32'hFFFF_FFFF, 1'b0, 2, 0, 32'd0});
    v.push_back('{1'b0, 3'b100, 32'h11, 32'd0, 32'h0000_00FF, 1'b0, 2, 0, 32'd0});
    foreach (v[i]) begin
      sb.push_back(v[i]);
      run(v[i], rd, er, lat, nw, wdin, wlat, ok);
      e = sb.pop_front();
      n_cmp++; if (!ok || rd !== e.rd || er !== e.err) begin n_bad++; $display("FAIL load_%0d: got rdata %h err %b want %h %b", i, rd, er, e.rd, e.err); end
      n_cmp++; if (lat != e.lat || nw != 0) begin n_bad++; $display("FAIL load_%0d_timing: got lat %0d writes %0d want %0d 0", i, lat, nw, e.lat); end
    end
  endtask

  task automatic test_stores;
    vec_t v[$];
    vec_t e;
    logic [31:0] rd, wdin;
    logic er;
    int lat, nw, wlat;
    bit ok;
    poke(2, 32'h1122_3344);
    v.push_back('{1'b1, 3'b001, 32'h0A, 32'h0000_ABCD, 32'd0, 1'b0, 3, 2, 32'hABCD_3344});
    v.push_back('{1'b1, 3'b000, 32'h09, 32'h0000_005A, 32'd0, 1'b0, 3, 2, 32'hABCD_5A44});
    v.push_back('{1'b1, 3'b000, 32'h08, 32'hFFFF_FF77, 32'd0, 1'b0, 3, 2, 32'hABCD_5A77});
    v.push_back('{1'b1, 3'b001, 32'h08, 32'h1234_9876, 32'd0, 1'b0, 3, 2, 32'hABCD_9876});
    v.push_back('{1'b1, 3'b010, 32'h0C, 32'h1234_5678, 32'd0, 1'b0, 2, 1, 32'h1234_5678});
    v.push_back('{1'b0, 3'b001, 32'h0A, 32'd0, 32'hFFFF_ABCD, 1'b0, 2, 0, 32'd0});
    foreach (v[i]) begin
      sb.push_back(v[i]);
      run(v[i], rd, er, lat, nw, wdin, wlat, ok);
      e = sb.pop_front();
      n_cmp++; if (!ok || rd !== e.rd || er !== e.err || lat != e.lat) begin n_bad++; $display("FAIL store_%0d_resp: got rdata %h err %b lat %0d want %h %b %0d", i, rd, er, lat, e.rd, e.err, e.lat); end
      n_cmp++; if (nw != (e.wlat > 0 ? 1 : 0)) begin n_bad++; $display("FAIL store_%0d_pulses: got %0d want %0d", i, nw, (e.wlat > 0 ? 1 : 0)); end
      if (e.wlat > 0) begin
        n_cmp++; if (wdin !== e.wdin || wlat != e.wlat) begin n_bad++; $display("FAIL store_%0d_write: got data %h at %0d want %h at %0d", i, wdin, wlat, e.wdin, e.wlat); end
      end
    end
    n_cmp++; if (ram[2] !== 32'hABCD_9876) begin n_bad++; $display("FAIL store_ram2: got %h want abcd9876", ram[2]); end
    n_cmp++; if (ram[3] !== 32'h1234_5678) begin n_bad++; $display("FAIL store_ram3: got %h want 12345678", ram[3]); end
  endtask

  task automatic test_errors;
    vec_t v[$];
    vec_t e;
    logic [31:0] rd, wdin;
    logic er;
    int lat, nw, wlat;
    bit ok;
    poke(31, 32'h5555_AAAA);
    v.push_back('{1'b0, 3'b001, 32'h01, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0});
    v.push_back('{1'b1, 3'b010, 32'h02, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 0, 32'd0});
    v.push_back('{1'b0, 3'b010, 32'h80, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0});
    v.push_back('{1'b0, 3'b011, 32'h00, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0});
    v.push_back('{1'b0, 3'b111, 32'h00, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0});
    v.push_back('{1'b1, 3'b100, 32'h04, 32'h0000_0011, 32'd0, 1'b1, 1, 0, 32'd0});
    v.push_back('{1'b0, 3'b101, 32'h03, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0});
    v.push_back('{1'b1, 3'b000, 32'h8000_0004, 32'h0000_0022, 32'd0, 1'b1, 1, 0, 32'd0});
    v.push_back('{1'b0, 3'b010, 32'h7C, 32'd0, 32'h5555_AAAA, 1'b0, 2, 0, 32'd0});
    foreach (v[i]) begin
      sb.push_back(v[i]);
      run(v[i], rd, er, lat, nw, wdin, wlat, ok);
      e = sb.pop_front();
      n_cmp++; if (!ok || rd !== e.rd || er !== e.err) begin n_bad++; $display("FAIL err_%0d: got rdata %h err %b want %h %b", i, rd, er, e.rd, e.err); end
      n_cmp++; if (lat != e.lat || nw != 0) begin n_bad++; $display("FAIL err_%0d_timing: got lat %0d writes %0d want %0d 0", i, lat, nw, e.lat); end
    end
  endtask

  task automatic test_backpressure;
    vec_t e;
    bit seen = 1'b0;
    sb.push_back('{1'b0, 3'b010, 32'h10, 32'd0, 32'h80FF_FFFF, 1'b0, 2, 0, 32'd0});
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 3'b010;
    bus.req_addr = 32'h10; bus.req_wdata = 32'd0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.resp_valid;
    end
    e = sb.pop_front();
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_resp_timeout: got no resp_valid want 1"); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rd || bus.req_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold_%0d: got valid %b rdata %h ready %b want 1 %h 0", k, bus.resp_valid, bus.resp_rdata, bus.req_ready, e.rd);
      end
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got valid %b ready %b want 0 1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_reset_merge;
    bit seen = 1'b0;
    int w0, bad_resp;
    poke(5, 32'hCAFE_F00D);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 3'b000;
    bus.req_addr = 32'h15; bus.req_wdata = 32'h0000_0011;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.data_w_en;
    end
    n_cmp++; if (!seen || bus.data_in !== 32'hCAFE_110D) begin n_bad++; $display("FAIL rm_merge: got en %b data %h want 1 cafe110d", seen, bus.data_in); end
    rst_n = 1'b0;
    #1;
    w0 = wen_cnt;
    n_cmp++; if (bus.data_w_en !== 1'b0 || bus.data_in !== 32'd0 || bus.data_addr !== 32'd0) begin
      n_bad++; $display("FAIL rm_async_clear: got en %b data %h addr %h want 0 0 0", bus.data_w_en, bus.data_in, bus.data_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad_resp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) bad_resp++;
    end
    n_cmp++; if (bad_resp != 0) begin n_bad++; $display("FAIL rm_no_resp: got %0d valid cycles want 0", bad_resp); end
    n_cmp++; if (wen_cnt != w0) begin n_bad++; $display("FAIL rm_no_write: got %0d pulses want 0", wen_cnt - w0); end
    n_cmp++; if (ram[5] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL rm_ram: got %h want cafef00d", ram[5]); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %b want 1", bus.req_ready); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b1;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_backpressure();
    test_reset_merge();
    n_cmp++; if (din_leak != 0) begin n_bad++; $display("FAIL data_in_idle: got %0d nonzero cycles want 0", din_leak); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter ADDR_BITS, default 7, SHALL be the byte-address width of the attached data RAM; any address bit at or above ADDR_BITS set to 1 is out of range.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port req_valid  input  1  SHALL be the request valid.
REQ-005 Port req_ready  output  1  SHALL be the request ready.
REQ-006 Port req_we  input  1  SHALL select store (1) or load (0).
REQ-007 Port req_size  input  3  SHALL be funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 Port req_addr  input  32  SHALL be the byte address.
REQ-009 Port req_wdata  input  32  SHALL be store data, right-aligned.
REQ-010 Port resp_valid  output  1  SHALL be the response valid.
REQ-011 Port resp_ready  input  1  SHALL be the response accept.
REQ-012 Port resp_rdata  output  32  SHALL be load data, extended to 32 bits.
REQ-013 Port resp_err  output  1  SHALL flag a misaligned, out-of-range or illegal request.
REQ-014 Port data_w_en  output  1  SHALL be the RAM write enable.
REQ-015 Port data_addr  output  32  SHALL be the RAM address, word-aligned ({addr[31:2],2'b00}).
REQ-016 Port data_in  output  32  SHALL be the RAM write data.
REQ-017 Port data_out  input  32  SHALL be the RAM combinational read data.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, MERGE_WR, RESP; req_ready = 1 only in IDLE.
REQ-019 Acceptance SHALL occur on a rising edge with req_valid & req_ready; req_we, req_size, req_addr and req_wdata are latched at that edge.
REQ-020 A request is in error if any of the following holds: req_size is 011, 110 or 111; req_we=1 with req_size[2]=1; H/HU with addr[0]=1; W with addr[1:0]!=0; or addr[31:ADDR_BITS]!=0.
REQ-021 An error request SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and SHALL produce no data_w_en pulse.
REQ-022 A valid request SHALL go IDLE->ACCESS; data_addr SHALL be driven from the latched address in ACCESS and MERGE_WR.
REQ-023 Load in ACCESS: the selected lane of data_out is captured, then zero-extended (BU/HU) or sign-extended (B/H) into resp_rdata; ACCESS->RESP.
REQ-024 Byte lane SHALL be addr[1:0] (B/BU); halfword lane SHALL be addr[1] (H/HU); W passes data_out unchanged.
REQ-025 SW in ACCESS: data_w_en=1 and data_in=latched wdata for exactly that cycle; ACCESS->RESP.
REQ-026 SB/SH in ACCESS: data_out is merged with the latched wdata low byte/halfword into the addressed lane and registered; ACCESS->MERGE_WR.
REQ-027 MERGE_WR: data_w_en=1 and data_in=merged word for exactly one cycle; MERGE_WR->RESP; bytes outside the target lane are preserved.
REQ-028 data_w_en SHALL be 0 in all other states, and data_in SHALL be 0 whenever data_w_en=0.
REQ-029 RESP: resp_valid=1 with resp_rdata and resp_err held stable until resp_ready=1; RESP->IDLE on that edge.
REQ-030 Stores SHALL respond with resp_rdata=0, resp_err=0.
REQ-031 Latency from the accept edge to resp_valid high SHALL be 1 cycle for error, 2 cycles for load/SW and 3 cycles for SB/SH.
REQ-032 No new request SHALL be accepted in the same cycle a response is retired (req_ready rises the cycle after).

Reset
REQ-033 While rst_n=0, regardless of clk: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, all latched/merge registers=0, data_w_en=0, data_in=0, data_addr=0.
REQ-034 Reset asserted in ACCESS or MERGE_WR SHALL abandon the operation with no further data_w_en pulse, and SHALL issue no response after release.
REQ-035 After rst_n deasserts, req_ready SHALL be 1 from the first clock edge.

Verification
REQ-036 Scenario LW at 0x10, RAM[4]=0xDEADBEEF, resp_ready=1: response at accept+2 with resp_rdata=0xDEADBEEF, resp_err=0.
REQ-037 Scenario LB and LBU at 0x13, RAM[4]=0x80FFFFFF: LB returns 0xFFFFFF80; LBU returns 0x00000080.
REQ-038 Scenario SH 0xABCD to 0x0A, RAM[2]=0x11223344: one data_w_en pulse at accept+2 with data_in=0xABCD3344, then response at accept+3.
REQ-039 Scenario LH at 0x01, SW at 0x02, and LW at 0x80 (ADDR_BITS=7): each returns resp_err=1 at accept+1 with no data_w_en pulse.
REQ-040 Scenario resp_ready held 0 for 5 cycles: resp_valid/resp_rdata remain stable and req_ready=0 throughout; on release, IDLE follows.
REQ-041 Scenario rst_n pulsed low during MERGE_WR of an SB: data_w_en=0 thereafter, RAM word unchanged, no resp_valid, and req_ready=1 after release.
